// File: rtl/control_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : control_bram_arbiter
// Purpose  : Shares one single-port control BRAM between the instruction-side
//            port (req0) and the load/store port (req1). Round-robin grant
//            with optional bounded burst lock; read data returned as a
//            registered one-cycle pulse to the requester that issued it.
// Revision : 1.0 - initial release
// ============================================================================
module control_bram_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 20,
  parameter int MAX_LOCK = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req0_valid,
  input  logic          i_req0_we,
  input  logic          i_req0_lock,
  input  logic [AW-1:0] i_req0_addr,
  input  logic [DW-1:0] i_req0_wdata,
  output logic          o_req0_ready,
  output logic          o_rsp0_valid,
  output logic [DW-1:0] o_rsp0_rdata,
  input  logic          i_req1_valid,
  input  logic          i_req1_we,
  input  logic          i_req1_lock,
  input  logic [AW-1:0] i_req1_addr,
  input  logic [DW-1:0] i_req1_wdata,
  output logic          o_req1_ready,
  output logic          o_rsp1_valid,
  output logic [DW-1:0] o_rsp1_rdata,
  output logic [AW-1:0] o_bram_addr,
  output logic          o_bram_rden,
  output logic          o_bram_wren,
  output logic [DW-1:0] o_bram_wdata,
  input  logic [DW-1:0] i_bram_rdata
);

  localparam int c_cnt_w = $clog2(MAX_LOCK + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_LOCK);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  localparam logic [1:0] c_st_arb   = 2'd0;
  localparam logic [1:0] c_st_lock0 = 2'd1;
  localparam logic [1:0] c_st_lock1 = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               prio_q, prio_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [1:0]         rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]      rsp0_rdata_q, rsp0_rdata_d;
  logic [DW-1:0]      rsp1_rdata_q, rsp1_rdata_d;

  logic [1:0] w_valid;
  logic [1:0] w_we;
  logic [1:0] w_lock;
  logic [1:0] w_gnt;
  logic       w_locked;
  logic       w_owner;
  logic       w_starve;
  logic       w_eff_prio;
  logic       w_win;

  assign w_valid = {i_req1_valid, i_req0_valid};
  assign w_we    = {i_req1_we,    i_req0_we};
  assign w_lock  = {i_req1_lock,  i_req0_lock};

  // Grant decision and next arbitration state (lock ownership, pointer, counter)
  always_comb begin
    w_locked   = (state_q == c_st_lock0) || (state_q == c_st_lock1);
    w_owner    = (state_q == c_st_lock1);
    // A saturated lock yields to a waiting partner: evaluate as plain ARB with
    // the partner holding priority.
    w_starve   = w_locked && (cnt_q == c_cnt_max) && w_valid[~w_owner];
    w_eff_prio = w_starve ? ~w_owner : prio_q;
    w_gnt      = 2'b00;
    w_win      = 1'b0;
    state_d    = c_st_arb;
    cnt_d      = '0;
    prio_d     = prio_q;
    if (i_rst) begin
      w_gnt = 2'b00;
    end else if (w_locked && w_valid[w_owner] && !w_starve) begin
      w_gnt[w_owner] = 1'b1;
      w_win          = w_owner;
      prio_d         = ~w_owner;
      if (w_lock[w_owner]) begin
        state_d = state_q;
        cnt_d   = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + c_cnt_one;
      end
    end else begin
      if (&w_valid) begin
        w_gnt[w_eff_prio] = 1'b1;
      end else begin
        w_gnt = w_valid;
      end
      w_win = w_gnt[1];
      if (|w_gnt) begin
        prio_d = ~w_win;
        if (w_lock[w_win]) begin
          state_d = w_win ? c_st_lock1 : c_st_lock0;
          cnt_d   = c_cnt_one;
        end
      end
    end
  end

  // BRAM drive: winner's address/data, zero when no grant
  always_comb begin
    o_bram_addr  = '0;
    o_bram_wdata = '0;
    o_bram_rden  = 1'b0;
    o_bram_wren  = 1'b0;
    if (|w_gnt) begin
      o_bram_addr  = w_win ? i_req1_addr  : i_req0_addr;
      o_bram_wdata = w_win ? i_req1_wdata : i_req0_wdata;
      o_bram_rden  = ~w_we[w_win];
      o_bram_wren  = w_we[w_win];
    end
  end

  // Response capture: BRAM data is valid by the rising edge closing the issue cycle
  always_comb begin
    rsp_valid_d  = w_gnt & ~w_we;
    rsp0_rdata_d = rsp_valid_d[0] ? i_bram_rdata : rsp0_rdata_q;
    rsp1_rdata_d = rsp_valid_d[1] ? i_bram_rdata : rsp1_rdata_q;
  end

  // State and response registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= c_st_arb;
      prio_q       <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= 2'b00;
      rsp0_rdata_q <= '0;
      rsp1_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

  // Reset suppresses a response that would otherwise land in the reset cycle
  assign o_req0_ready = w_gnt[0];
  assign o_req1_ready = w_gnt[1];
  assign o_rsp0_valid = rsp_valid_q[0] & ~i_rst;
  assign o_rsp1_valid = rsp_valid_q[1] & ~i_rst;
  assign o_rsp0_rdata = rsp0_rdata_q;
  assign o_rsp1_rdata = rsp1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_control_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_bram_arbiter
// Purpose  : Self-checking bench for control_bram_arbiter with a BRAM model
//            and a behavioural arbitration/response reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_bram_arbiter;

  localparam int AW = 10;
  localparam int DW = 20;
  localparam int MAX_LOCK = 8;
  localparam int VW = 4 + AW + DW + 2 + 2 * DW;

  logic          clk;
  logic          rst;
  logic [1:0]    v, we, lk;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wd [2];
  logic          rdy0, rdy1, rv0, rv1;
  logic [DW-1:0] rd0, rd1;
  logic [AW-1:0] baddr;
  logic          brden, bwren;
  logic [DW-1:0] bwdata, brdata;

  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] ref_mem [1 << AW];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state: owner of the lock (-1 none), consecutive locked grants, priority
  int            m_owner, m_run, m_win;
  logic          m_prio;
  logic [1:0]    pend_v;
  logic [DW-1:0] pend_d0, pend_d1;
  logic [VW-1:0] e_vec;

  control_bram_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(MAX_LOCK)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v[0]), .i_req0_we(we[0]), .i_req0_lock(lk[0]),
    .i_req0_addr(addr[0]), .i_req0_wdata(wd[0]),
    .o_req0_ready(rdy0), .o_rsp0_valid(rv0), .o_rsp0_rdata(rd0),
    .i_req1_valid(v[1]), .i_req1_we(we[1]), .i_req1_lock(lk[1]),
    .i_req1_addr(addr[1]), .i_req1_wdata(wd[1]),
    .o_req1_ready(rdy1), .o_rsp1_valid(rv1), .o_rsp1_rdata(rd1),
    .o_bram_addr(baddr), .o_bram_rden(brden), .o_bram_wren(bwren),
    .o_bram_wdata(bwdata), .i_bram_rdata(brdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single-port BRAM: read latched on falling edge, write on rising edge
  always @(negedge clk) if (brden) brdata <= mem[baddr];
  always @(posedge clk) if (bwren) mem[baddr] <= bwdata;

  function automatic logic [VW-1:0] obs_vec();
    return {rdy1, rdy0, brden, bwren, baddr, bwdata, rv1, rv0, rd1, rd0};
  endfunction

  task automatic model_reset();
    m_owner = -1; m_run = 0; m_prio = 1'b0; m_win = -1;
    pend_v = 2'b00; pend_d0 = '0; pend_d1 = '0;
  endtask

  // Computes this cycle's expected outputs from current inputs, then advances the model
  task automatic model_step();
    int            win;
    logic          oth, starve, p, gw;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    oth    = (m_owner == 0);
    starve = (m_owner >= 0) && (m_run >= MAX_LOCK) && v[oth];
    if (m_owner >= 0 && v[m_owner[0]] && !starve) win = m_owner;
    else begin
      p = starve ? oth : m_prio;
      if (v == 2'b11) win = p ? 1 : 0;
      else if (v[0]) win = 0;
      else if (v[1]) win = 1;
      else win = -1;
    end
    ea = '0; ed = '0; gw = 1'b0;
    if (win >= 0) begin ea = addr[win[0]]; ed = wd[win[0]]; gw = we[win[0]]; end
    e_vec = {win == 1, win == 0, win >= 0 && !gw, win >= 0 && gw, ea, ed,
             pend_v[1], pend_v[0], pend_d1, pend_d0};
    pend_v = 2'b00;
    if (win >= 0) begin
      if (!gw) begin
        pend_v[win[0]] = 1'b1;
        if (win == 0) pend_d0 = ref_mem[ea]; else pend_d1 = ref_mem[ea];
      end else ref_mem[ea] = ed;
      m_prio = (win == 0);
      if (lk[win[0]]) begin
        m_run   = (m_owner == win) ? ((m_run < MAX_LOCK) ? m_run + 1 : m_run) : 1;
        m_owner = win;
      end else begin m_owner = -1; m_run = 0; end
    end else begin m_owner = -1; m_run = 0; end
    m_win = win;
  endtask

  task automatic idle_inputs();
    v = 2'b00; we = 2'b00; lk = 2'b00;
    addr[0] = '0; addr[1] = '0; wd[0] = '0; wd[1] = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs_vec() !== '0) $display("FAIL reset_outputs: got %h want 0", obs_vec());
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    @(negedge clk); model_step();
    n_checks++;
    if (obs_vec() !== e_vec) $display("FAIL idle_after_reset: got %h want %h", obs_vec(), e_vec);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_single_read();
    v = 2'b01; we = 2'b00; addr[0] = 10'h005;
    @(negedge clk); model_step();
    n_checks++;
    if (obs_vec() !== e_vec) $display("FAIL read_issue: got %h want %h", obs_vec(), e_vec);
    else n_pass++;
    @(posedge clk); #1 idle_inputs();
    @(negedge clk); model_step();
    n_checks++;
    if (obs_vec() !== e_vec) $display("FAIL read_rsp_model: got %h want %h", obs_vec(), e_vec);
    else n_pass++;
    n_checks++;
    if (!(rv0 === 1'b1 && rd0 === 20'h0ABCD && rv1 === 1'b0))
      $display("FAIL read_rsp_data: got v=%b d=%h want v=1 d=0abcd", rv0, rd0);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_write_then_read();
    v = 2'b10; we = 2'b10; addr[1] = 10'h3FF; wd[1] = 20'h12345;
    @(negedge clk); model_step();
    n_checks++;
    if (obs_vec() !== e_vec || bwren !== 1'b1)
      $display("FAIL write_issue: got %h want %h", obs_vec(), e_vec);
    else n_pass++;
    @(posedge clk); #1 we = 2'b00;
    @(negedge clk); model_step();
    n_checks++;
    if (obs_vec() !== e_vec) $display("FAIL raw_read_issue: got %h want %h", obs_vec(), e_vec);
    else n_pass++;
    @(posedge clk); #1 idle_inputs();
    @(negedge clk); model_step();
    n_checks++;
    if (!(rv1 === 1'b1 && rd1 === 20'h12345 && obs_vec() === e_vec))
      $display("FAIL raw_read_data: got v=%b d=%h want v=1 d=12345", rv1, rd1);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_alternation();
    int first;
    v = 2'b11; we = 2'b00; lk = 2'b00;
    addr[0] = AW'($urandom); addr[1] = AW'($urandom);
    first = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); model_step();
      if (i == 0) first = m_win;
      n_checks++;
      if (obs_vec() !== e_vec) $display("FAIL alt_model c%0d: got %h want %h", i, obs_vec(), e_vec);
      else n_pass++;
      n_checks++;
      if (rdy1 !== 1'(first ^ (i & 1)))
        $display("FAIL alt_order c%0d: got rdy1=%b want %0d", i, rdy1, first ^ (i & 1));
      else n_pass++;
      @(posedge clk); #1;
      if (m_win >= 0) addr[m_win[0]] = AW'($urandom);
    end
    idle_inputs();
    @(negedge clk); model_step();
    n_checks++;
    if (obs_vec() !== e_vec) $display("FAIL alt_drain: got %h want %h", obs_vec(), e_vec);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_lock_bound();
    // a lone req1 grant leaves priority with req0
    v = 2'b10; we = 2'b00; addr[1] = 10'h010;
    @(negedge clk); model_step();
    @(posedge clk); #1;
    v = 2'b11; lk = 2'b01; addr[0] = 10'h020; addr[1] = 10'h030;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); model_step();
      n_checks++;
      if (obs_vec() !== e_vec) $display("FAIL lock_model c%0d: got %h want %h", i, obs_vec(), e_vec);
      else n_pass++;
      n_checks++;
      if ({rdy1, rdy0} !== ((i % 9 == 8) ? 2'b10 : 2'b01))
        $display("FAIL lock_bound c%0d: got %b want %b", i, {rdy1, rdy0}, (i % 9 == 8) ? 2'b10 : 2'b01);
      else n_pass++;
      @(posedge clk); #1;
      if (m_win >= 0) addr[m_win[0]] = addr[m_win[0]] + 1'b1;
    end
    idle_inputs();
    @(negedge clk); model_step();
    @(posedge clk); #1;
  endtask

  task automatic test_lock_idle();
    v = 2'b01; we = 2'b00; lk = 2'b01; addr[0] = 10'h100;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); model_step();
      n_checks++;
      if ({rdy1, rdy0} !== 2'b01 || obs_vec() !== e_vec)
        $display("FAIL lock_idle c%0d: got %h want %h", i, obs_vec(), e_vec);
      else n_pass++;
      @(posedge clk); #1 addr[0] = addr[0] + 1'b1;
    end
    // saturated counter: a newly waiting req1 wins at once
    v = 2'b11; addr[1] = 10'h200;
    @(negedge clk); model_step();
    n_checks++;
    if ({rdy1, rdy0} !== 2'b10 || obs_vec() !== e_vec)
      $display("FAIL lock_saturated_yield: got %h want %h", obs_vec(), e_vec);
    else n_pass++;
    @(posedge clk); #1 idle_inputs();
    @(negedge clk); model_step();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); model_step();
      n_checks++;
      if (obs_vec() !== e_vec) begin
        if (errs < 10) $display("FAIL random c%0d: got %h want %h", c, obs_vec(), e_vec);
        errs++;
      end else n_pass++;
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (!v[n] || m_win == n) begin
          v[n]    = ($urandom_range(0, 99) < 70);
          we[n]   = ($urandom_range(0, 3) == 0);
          lk[n]   = ($urandom_range(0, 4) == 0);
          addr[n] = AW'($urandom_range(0, 15));
          wd[n]   = DW'($urandom);
        end
      end
    end
    idle_inputs();
    @(negedge clk); model_step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read();
    v = 2'b10; we = 2'b00; lk = 2'b00; addr[1] = 10'h3FF;
    @(negedge clk); model_step();
    n_checks++;
    if (obs_vec() !== e_vec || rdy1 !== 1'b1)
      $display("FAIL rst_mid_issue: got %h want %h", obs_vec(), e_vec);
    else n_pass++;
    @(posedge clk); #1 rst = 1'b1; idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({rv1, rv0, rdy1, rdy0, brden, bwren} !== 6'b0)
      $display("FAIL rst_mid_suppress: got %b want 000000", {rv1, rv0, rdy1, rdy0, brden, bwren});
    else n_pass++;
    @(posedge clk); #1 rst = 1'b0; model_reset();
    v = 2'b11; addr[0] = 10'h005; addr[1] = 10'h3FF;
    @(negedge clk); model_step();
    n_checks++;
    if ({rdy1, rdy0} !== 2'b01 || obs_vec() !== e_vec)
      $display("FAIL rst_prio0: got %h want %h", obs_vec(), e_vec);
    else n_pass++;
    @(posedge clk); #1 idle_inputs();
    @(negedge clk); model_step();
    n_checks++;
    if (obs_vec() !== e_vec) $display("FAIL rst_after_rsp: got %h want %h", obs_vec(), e_vec);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  initial begin
    brdata = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i] = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[5] = 20'h0ABCD; ref_mem[5] = 20'h0ABCD;
    model_reset();
    test_reset();
    test_single_read();
    test_write_then_read();
    test_alternation();
    test_lock_bound();
    test_lock_idle();
    test_random();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
